// File: rtl/readout_sequencer.sv
// Row-readout controller: walks every pixel row, loads it into the output buffer, waits for drain.
// Optional start watchdog enabled by defining READOUT_SEQUENCER_TIMEOUT_EN.
module readout_sequencer #(
   parameter int PIXEL_ARRAY_HEIGHT = 4,
   parameter int SETTLE_CYCLES      = 2,
   parameter int START_TIMEOUT      = 8
) (
   input  logic                                                              CLK,
   input  logic                                                              RESET,
   input  logic                                                              READOUT_START,
   input  logic                                                              BUFFER_BUSY,
   output logic                                                              SET_BUFFER,
   output logic [PIXEL_ARRAY_HEIGHT-1:0]                                     ROW_SELECT,
   output logic [((PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1)-1:0] ROW_INDEX,
   output logic                                                              READOUT_BUSY,
   output logic                                                              READOUT_DONE,
   output logic                                                              READOUT_ERROR
);

   localparam int IW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [IW-1:0] LAST_ROW = IW'(PIXEL_ARRAY_HEIGHT - 1);
   // SETTLE_CYCLES of 0 and 1 both give a single SELECT cycle.
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [PIXEL_ARRAY_HEIGHT-1:0] FIRST_ROW = PIXEL_ARRAY_HEIGHT'(32'd1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SELECT     = 3'd1,
      LOAD       = 3'd2,
      WAIT_START = 3'd3,
      WAIT_DRAIN = 3'd4,
      NEXT       = 3'd5
   } state_t;

   state_t          state;
   logic [SW-1:0]   settle_cnt;

`ifdef READOUT_SEQUENCER_TIMEOUT_EN
   localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'((START_TIMEOUT > 1) ? START_TIMEOUT - 1 : 0);
   logic [TW-1:0]   watchdog;
   logic            error_flag;

   assign READOUT_ERROR = error_flag;
`else
   assign READOUT_ERROR = 1'b0;
`endif

   // Sequencer state, counters and all registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         SET_BUFFER   <= 1'b0;
         ROW_SELECT   <= '0;
         ROW_INDEX    <= '0;
         READOUT_BUSY <= 1'b0;
         READOUT_DONE <= 1'b0;
`ifdef READOUT_SEQUENCER_TIMEOUT_EN
         watchdog     <= '0;
         error_flag   <= 1'b0;
`endif
      end else begin
         SET_BUFFER   <= 1'b0;
         READOUT_DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (READOUT_START) begin
                  state        <= SELECT;
                  settle_cnt   <= '0;
                  ROW_INDEX    <= '0;
                  ROW_SELECT   <= FIRST_ROW;
                  READOUT_BUSY <= 1'b1;
               end
            end
            SELECT: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= LOAD;
                  SET_BUFFER <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            LOAD: begin
               state <= WAIT_START;
`ifdef READOUT_SEQUENCER_TIMEOUT_EN
               watchdog <= '0;
`endif
            end
            WAIT_START: begin
               if (BUFFER_BUSY) begin
                  state <= WAIT_DRAIN;
`ifdef READOUT_SEQUENCER_TIMEOUT_EN
               end else if (watchdog == TIMEOUT_LAST) begin
                  // Buffer never started: abort the frame without a done pulse.
                  state        <= IDLE;
                  error_flag   <= 1'b1;
                  ROW_SELECT   <= '0;
                  ROW_INDEX    <= '0;
                  READOUT_BUSY <= 1'b0;
               end else begin
                  watchdog <= watchdog + 1'b1;
`endif
               end
            end
            WAIT_DRAIN: begin
               if (!BUFFER_BUSY) begin
                  state <= NEXT;
                  // Last row: the NEXT cycle itself carries the done pulse, so a start
                  // request seen there is dropped and only honoured once back in IDLE.
                  if (ROW_INDEX == LAST_ROW) begin
                     READOUT_DONE <= 1'b1;
                     READOUT_BUSY <= 1'b0;
                     ROW_SELECT   <= '0;
                     ROW_INDEX    <= '0;
                  end
               end
            end
            NEXT: begin
               if (READOUT_DONE) begin
                  state <= IDLE;
               end else begin
                  state      <= SELECT;
                  settle_cnt <= '0;
                  ROW_INDEX  <= ROW_INDEX + 1'b1;
                  ROW_SELECT <= ROW_SELECT << 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               ROW_SELECT   <= '0;
               ROW_INDEX    <= '0;
               READOUT_BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_readout_sequencer.sv
// Table-driven bench for readout_sequencer: H=4/SETTLE=2 instance plus an H=1/SETTLE=0 instance.
// Timeout checks are compiled in when READOUT_SEQUENCER_TIMEOUT_EN is defined.
module tb_readout_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic       start_a, busy_a, set_a, bsy_a, done_a, err_a;
   logic [3:0] sel_a;
   logic [1:0] idx_a;
   logic       start_b, busy_b, set_b, bsy_b, done_b, err_b;
   logic [0:0] sel_b;
   logic [0:0] idx_b;

   readout_sequencer #(.PIXEL_ARRAY_HEIGHT(4), .SETTLE_CYCLES(2), .START_TIMEOUT(8)) dut (
      .CLK(clk), .RESET(rst), .READOUT_START(start_a), .BUFFER_BUSY(busy_a),
      .SET_BUFFER(set_a), .ROW_SELECT(sel_a), .ROW_INDEX(idx_a),
      .READOUT_BUSY(bsy_a), .READOUT_DONE(done_a), .READOUT_ERROR(err_a));

   readout_sequencer #(.PIXEL_ARRAY_HEIGHT(1), .SETTLE_CYCLES(0), .START_TIMEOUT(8)) dut1 (
      .CLK(clk), .RESET(rst), .READOUT_START(start_b), .BUFFER_BUSY(busy_b),
      .SET_BUFFER(set_b), .ROW_SELECT(sel_b), .ROW_INDEX(idx_b),
      .READOUT_BUSY(bsy_b), .READOUT_DONE(done_b), .READOUT_ERROR(err_b));

   // Expected output word: {set, sel[3:0], idx[1:0], busy, done}
   typedef struct {
      logic       start;
      logic       busy;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;
   logic exp_err = 1'b0;
   int   n_set = 0, n_done = 0, n_done_b = 0;

   always @(negedge clk) begin
      if (set_a)  n_set++;
      if (done_a) n_done++;
      if (done_b) n_done_b++;
   end

   function automatic logic [8:0] pk(input logic s, input logic [3:0] sel, input logic [1:0] idx,
                                     input logic b, input logic d);
      return {s, sel, idx, b, d};
   endfunction

   task automatic add(input logic st, input logic bz, input logic [8:0] e);
      vec_t v;
      v.start = st; v.busy = bz; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input int i);
      @(negedge clk);
      start_a = tbl[i].start;
      busy_a  = tbl[i].busy;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {6'd0, err_a, set_a, sel_a, idx_a, bsy_a, done_a},
            {6'd0, exp_err, tbl[i].exp});
   endtask

   initial begin
      logic [3:0] sel;
      int         base;
      logic [8:0] same;

      // Frame of 4 rows; START pulses during row 1 and in the DONE cycle must be ignored.
      add(1'b1, 1'b0, pk(1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
      for (int r = 0; r < 4; r++) begin
         sel  = 4'b0001 << r;
         same = pk(1'b0, sel, 2'(r), 1'b1, 1'b0);
         add(1'b0, 1'b0, same);
         add(1'b0, 1'b0, pk(1'b1, sel, 2'(r), 1'b1, 1'b0));
         add(1'b0, 1'b0, same);
         add((r == 1) ? 1'b1 : 1'b0, 1'b1, same);
         add(1'b0, 1'b1, same);
         add(1'b0, 1'b0, (r < 3) ? same : pk(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1));
         add((r == 3) ? 1'b1 : 1'b0, 1'b0,
             (r < 3) ? pk(1'b0, sel << 1, 2'(r + 1), 1'b1, 1'b0) : 9'd0);
      end
      add(1'b0, 1'b0, 9'd0);
      add(1'b0, 1'b0, 9'd0);

      rst = 1'b1; start_a = 1'b0; busy_a = 1'b0; start_b = 1'b0; busy_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", {6'd0, err_a, set_a, sel_a, idx_a, bsy_a, done_a}, 16'd0);
      check("reset_b", {10'd0, err_b, set_b, sel_b, idx_b, bsy_b, done_b}, 16'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", {6'd0, err_a, set_a, sel_a, idx_a, bsy_a, done_a}, 16'd0);

      // Full frame.
      base = n_set;
      for (int i = 0; i < tbl.size(); i++) apply(i);
      check("set_count", 16'(n_set - base), 16'd4);
      check("done_count", 16'(n_done), 16'd1);

      // Reset during the first WAIT_DRAIN cycle of row 2.
      for (int i = 0; i <= 18; i++) apply(i);
      #2; rst = 1'b1; #1;
      check("async_reset", {6'd0, err_a, set_a, sel_a, idx_a, bsy_a, done_a}, 16'd0);
      @(negedge clk); rst = 1'b0; start_a = 1'b0; busy_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_resume", {6'd0, err_a, set_a, sel_a, idx_a, bsy_a, done_a}, 16'd0);
      base = n_done;
      for (int i = 0; i < tbl.size(); i++) apply(i);
      check("done_after_restart", 16'(n_done - base), 16'd1);

      // H=1, SETTLE=0, buffer already busy at LOAD, START held for three frames.
      base = n_done_b;
      for (int i = 0; i < 21; i++) begin
         int m;
         m = i % 6;
         @(negedge clk);
         start_b = (i < 18) ? 1'b1 : 1'b0;
         busy_b  = (i < 18 && (m == 2 || m == 3)) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         if (i < 18)
            check($sformatf("h1_cyc%0d", i), {11'd0, err_b, set_b, sel_b, bsy_b, done_b},
                  {12'd0, (m == 1) ? 1'b1 : 1'b0, (m <= 3) ? 1'b1 : 1'b0,
                   (m <= 3) ? 1'b1 : 1'b0, (m == 4) ? 1'b1 : 1'b0});
         else
            check($sformatf("h1_idle%0d", i), {11'd0, err_b, set_b, sel_b, bsy_b, done_b}, 16'd0);
      end
      check("h1_done_count", 16'(n_done_b - base), 16'd3);
      check("h1_index", {15'd0, idx_b}, 16'd0);

`ifdef READOUT_SEQUENCER_TIMEOUT_EN
      // Buffer stuck idle: eight WAIT_START cycles, then abort with sticky error.
      base = n_done;
      @(negedge clk); start_a = 1'b1; busy_a = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); start_a = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("to_before", {14'd0, err_a, bsy_a}, 16'h0001);
      @(posedge clk); #1;
      check("to_abort", {6'd0, err_a, set_a, sel_a, idx_a, bsy_a, done_a}, 16'h0200);
      repeat (2) @(posedge clk);
      #1;
      check("to_no_done", 16'(n_done - base), 16'd0);
      exp_err = 1'b1;
      for (int i = 0; i < tbl.size(); i++) apply(i);
      check("to_next_frame", 16'(n_done - base), 16'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
